// File: rtl/tx_filter.sv
// tx_filter: transmit-path FIR pulse-shaping filter.
// Each accepted sample is written into a circular history buffer, then one
// multiply-accumulate per clock runs over all TAPS entries (newest first)
// against coefficients read from an external combinational ROM. The sum is
// rounded half-up, shifted right by SHIFT and saturated to SAMPLE_BITS.
//
// Ports:
//   ctx_clk             tx clock
//   rtx_rst             asynchronous active-low reset
//   etx_en              enable; low clears all state on the next edge
//   isample             signed input sample
//   inew_sample         one-cycle strobe qualifying isample
//   ifilter_coefficient signed coefficient for address oselect_coefficient
//   oselect_coefficient coefficient ROM address (tap index)
//   osample             signed filtered sample, held until next update
//   osample_ready_trig  one-cycle pulse when osample updates
//   obusy               high while a computation is in progress
//   ooverrun            sticky: a strobe arrived while busy and was dropped
module tx_filter #(
  parameter int TAPS        = 64,
  parameter int SAMPLE_BITS = 16,
  parameter int COEF_BITS   = 16,
  parameter int ACC_BITS    = 40,
  parameter int SHIFT       = 15
) (
  input  logic                   ctx_clk,
  input  logic                   rtx_rst,
  input  logic                   etx_en,
  input  logic [SAMPLE_BITS-1:0] isample,
  input  logic                   inew_sample,
  input  logic [COEF_BITS-1:0]   ifilter_coefficient,
  output logic [7:0]             oselect_coefficient,
  output logic [SAMPLE_BITS-1:0] osample,
  output logic                   osample_ready_trig,
  output logic                   obusy,
  output logic                   ooverrun
);

  localparam int PTR_W  = $clog2(TAPS);
  localparam int PROD_W = SAMPLE_BITS + COEF_BITS;
  localparam int SH_M1  = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [8:0] TAPS_L = 9'(TAPS);
  localparam logic [7:0] LAST_K = 8'(TAPS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAPS - 1);
  // Half-LSB rounding constant; nothing to round when there is no shift.
  localparam logic signed [ACC_BITS:0] RND =
    (SHIFT > 0) ? (ACC_BITS+1)'(64'sd1 <<< SH_M1) : '0;
  localparam logic signed [ACC_BITS:0] SAT_MAX =
    (ACC_BITS+1)'((64'sd1 <<< (SAMPLE_BITS - 1)) - 64'sd1);
  localparam logic signed [ACC_BITS:0] SAT_MIN = -SAT_MAX - (ACC_BITS+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  state_t                         state_q, state_d;
  logic [SAMPLE_BITS-1:0]         hist_q [TAPS];
  logic [SAMPLE_BITS-1:0]         hist_d [TAPS];
  logic [PTR_W-1:0]               wptr_q, wptr_d;
  logic [PTR_W-1:0]               newest_q, newest_d;
  logic [7:0]                     k_q, k_d;
  logic signed [ACC_BITS-1:0]     acc_q, acc_d;
  logic [SAMPLE_BITS-1:0]         osample_q, osample_d;
  logic                           trig_q, trig_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;

  logic [8:0]                     idx_full;
  logic [PTR_W-1:0]               rd_idx;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_BITS-1:0]     prod_ext;
  logic signed [ACC_BITS:0]       round_sum;
  logic signed [ACC_BITS:0]       shifted;

  // Clamp a wide signed value into the output sample range.
  function automatic logic [SAMPLE_BITS-1:0] sat(input logic signed [ACC_BITS:0] v);
    logic [SAMPLE_BITS-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[SAMPLE_BITS-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[SAMPLE_BITS-1:0];
    end else begin
      r = v[SAMPLE_BITS-1:0];
    end
    return r;
  endfunction

  // History read index (newest - k) mod TAPS and the tap product.
  always_comb begin
    if ({1'b0, k_q} <= 9'(newest_q)) begin
      idx_full = 9'(newest_q) - {1'b0, k_q};
    end else begin
      idx_full = 9'(newest_q) + TAPS_L - {1'b0, k_q};
    end
    rd_idx   = idx_full[PTR_W-1:0];
    prod     = PROD_W'($signed(hist_q[rd_idx])) * PROD_W'($signed(ifilter_coefficient));
    prod_ext = ACC_BITS'(prod);
    // One extra bit keeps the rounding add from wrapping near full scale.
    round_sum = (ACC_BITS+1)'(acc_q) + RND;
    shifted   = round_sum >>> SHIFT;
  end

  // Next-state logic for the FSM, history buffer and output registers.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    wptr_d    = wptr_q;
    newest_d  = newest_q;
    k_d       = k_q;
    acc_d     = acc_q;
    osample_d = osample_q;
    trig_d    = 1'b0;
    overrun_d = overrun_q;
    if (!etx_en) begin
      state_d   = IDLE;
      for (int i = 0; i < TAPS; i++) begin
        hist_d[i] = '0;
      end
      wptr_d    = '0;
      newest_d  = '0;
      k_d       = 8'd0;
      acc_d     = '0;
      osample_d = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inew_sample) begin
            hist_d[wptr_q] = isample;
            newest_d       = wptr_q;
            if (wptr_q == LAST_PTR) begin
              wptr_d = '0;
            end else begin
              wptr_d = wptr_q + PTR_W'(1);
            end
            acc_d   = '0;
            k_d     = 8'd0;
            state_d = MAC;
          end else begin
            state_d = IDLE;
          end
        end
        MAC: begin
          if (inew_sample) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
          acc_d = acc_q + prod_ext;
          if (k_q == LAST_K) begin
            // Return the ROM address to tap 0 ready for the next sample.
            k_d     = 8'd0;
            state_d = DONE;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
        DONE: begin
          if (inew_sample) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
          osample_d = sat(shifted);
          trig_d    = 1'b1;
          k_d       = 8'd0;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
          k_d     = 8'd0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge ctx_clk or negedge rtx_rst) begin
    if (!rtx_rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
      wptr_q    <= '0;
      newest_q  <= '0;
      k_q       <= 8'd0;
      acc_q     <= '0;
      osample_q <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      wptr_q    <= wptr_d;
      newest_q  <= newest_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      osample_q <= osample_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign oselect_coefficient = k_q;
  assign osample             = osample_q;
  assign osample_ready_trig  = trig_q;
  assign obusy               = busy_q;
  assign ooverrun            = overrun_q;

endmodule

// File: tb/tb_tx_filter.sv
// Directed bench for tx_filter: a small instance (TAPS=4, SHIFT=2) for the
// impulse, wrap, rounding, overrun and reset cases, and a default instance
// for saturation. Inputs change and outputs are sampled on the falling edge.
module tb_tx_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en;

  logic [15:0] s_in, s_coef, s_out;
  logic        s_new, s_trig, s_busy, s_ovr;
  logic [7:0]  s_sel;
  logic signed [15:0] rom [4];

  logic [15:0] b_in, b_coef, b_out;
  logic        b_new, b_trig, b_busy, b_ovr;
  logic [7:0]  b_sel;

  int tests = 0;
  int fails = 0;

  always_comb s_coef = rom[s_sel[1:0]];
  assign b_coef = 16'sd32767;

  tx_filter #(.TAPS(4), .SAMPLE_BITS(16), .COEF_BITS(16), .ACC_BITS(40), .SHIFT(2)) u_small (
    .ctx_clk(clk), .rtx_rst(rst_n), .etx_en(en),
    .isample(s_in), .inew_sample(s_new), .ifilter_coefficient(s_coef),
    .oselect_coefficient(s_sel), .osample(s_out), .osample_ready_trig(s_trig),
    .obusy(s_busy), .ooverrun(s_ovr)
  );

  tx_filter u_big (
    .ctx_clk(clk), .rtx_rst(rst_n), .etx_en(en),
    .isample(b_in), .inew_sample(b_new), .ifilter_coefficient(b_coef),
    .oselect_coefficient(b_sel), .osample(b_out), .osample_ready_trig(b_trig),
    .obusy(b_busy), .ooverrun(b_ovr)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe one sample into the small instance; returns on the trigger cycle.
  task automatic run_small(input int smp, input int exp, input string tag);
    s_in  = 16'(smp);
    s_new = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) s_new = 1'b0;
      if (i == 1) check({tag, " trig_width"}, 32'(s_trig), 0);
      if (i == 3) check({tag, " busy"}, 32'(s_busy), 1);
      if (i > 1 && i < 6) check({tag, " trig_early"}, 32'(s_trig), 0);
      if (i == 6) begin
        check({tag, " trig"}, 32'(s_trig), 1);
        check({tag, " osample"}, 32'($signed(s_out)), exp);
      end
    end
  endtask

  // Strobe one sample into the default instance; returns on the trigger cycle.
  task automatic run_big(input int smp, input bit chk, input int exp, input string tag);
    b_in  = 16'(smp);
    b_new = 1'b1;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (i == 1) b_new = 1'b0;
    end
    check({tag, " trig"}, 32'(b_trig), 1);
    if (chk) check({tag, " osample"}, 32'($signed(b_out)), exp);
  endtask

  task automatic clear_en();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic impulse_seq(input string tag);
    rom[0] = 16'sd4; rom[1] = 16'sd8; rom[2] = 16'sd12; rom[3] = 16'sd16;
    run_small(100, 100, {tag, " imp0"});
    run_small(0, 200, {tag, " imp1"});
    run_small(0, 300, {tag, " imp2"});
    run_small(0, 400, {tag, " imp3"});
    run_small(0, 0, {tag, " imp4"});
    @(negedge clk);
    check({tag, " trig_end"}, 32'(s_trig), 0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; en = 1'b1;
    s_in = 16'd0; s_new = 1'b0; b_in = 16'd0; b_new = 1'b0;
    rom[0] = 16'sd0; rom[1] = 16'sd0; rom[2] = 16'sd0; rom[3] = 16'sd0;
    @(negedge clk);
    @(negedge clk);
    check("rst osample", 32'(s_out), 0);
    check("rst trig", 32'(s_trig), 0);
    check("rst busy", 32'(s_busy), 0);
    check("rst ovr", 32'(s_ovr), 0);
    check("rst sel", 32'(s_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    impulse_seq("first");

    // Wrap-around: y[n] = x[n] + x[n-3]
    clear_en();
    rom[0] = 16'sd4; rom[1] = 16'sd0; rom[2] = 16'sd0; rom[3] = 16'sd4;
    for (int n = 1; n <= 10; n++) begin
      run_small(n, (n <= 3) ? n : (2 * n - 3), "wrap");
    end

    // Rounding half up with arithmetic shift
    clear_en();
    rom[0] = 16'sd2; rom[1] = 16'sd0; rom[2] = 16'sd0; rom[3] = 16'sd0;
    run_small(1, 1, "round_p1");
    run_small(-1, 0, "round_m1");
    run_small(-3, -1, "round_m3");

    // Overrun: second strobe 3 clocks in is dropped
    clear_en();
    rom[0] = 16'sd4; rom[1] = 16'sd8; rom[2] = 16'sd12; rom[3] = 16'sd16;
    s_in = 16'd100; s_new = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) s_new = 1'b0;
      if (i == 3) begin s_in = 16'd50; s_new = 1'b1; end
      if (i == 4) begin
        s_new = 1'b0;
        check("ovr set", 32'(s_ovr), 1);
      end
    end
    check("ovr trig", 32'(s_trig), 1);
    check("ovr osample", 32'($signed(s_out)), 100);
    repeat (3) @(negedge clk);
    check("ovr sticky", 32'(s_ovr), 1);
    clear_en();
    check("ovr cleared", 32'(s_ovr), 0);
    check("en clr osample", 32'(s_out), 0);

    // Reset mid-MAC
    run_small(100, 100, "pre_rst");
    s_in = 16'd77; s_new = 1'b1;
    @(negedge clk);
    s_new = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid sel k2", 32'(s_sel), 2);
    #1 rst_n = 1'b0;
    #1;
    check("arst osample", 32'(s_out), 0);
    check("arst busy", 32'(s_busy), 0);
    check("arst sel", 32'(s_sel), 0);
    check("arst trig", 32'(s_trig), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | s_trig;
    end
    check("arst no trig", 32'(seen), 0);
    impulse_seq("after_rst");

    // Saturation on the default instance
    clear_en();
    for (int n = 1; n <= 64; n++) begin
      run_big(32767, (n == 1 || n == 2 || n == 64), (n == 1) ? 32766 : 32767, "sat_pos");
    end
    for (int n = 1; n <= 64; n++) begin
      run_big(-32768, (n == 1 || n == 64), (n == 1) ? 32767 : -32768, "sat_neg");
    end
    check("sat ovr", 32'(b_ovr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_filter.md
Name: tx_filter

Overview:
- Transmit-path FIR pulse-shaping filter. It sits between the TX symbol/sample generator and the DAC interface, mirroring the receive filter on the RX side.
- Each accepted input sample is stored in a circular history buffer.
- One multiply-accumulate runs per clock against coefficients fetched from an external coefficient ROM.
- Each output is rounded, scaled and saturated to 16 bits, then flagged with a single-cycle trigger.

Parameters:
- TAPS, 64: number of filter coefficients and history depth; 2 to 256.
- SAMPLE_BITS, 16: signed input/output sample width.
- COEF_BITS, 16: signed coefficient width.
- ACC_BITS, 40: signed accumulator width; must be at least SAMPLE_BITS+COEF_BITS+ceil(log2(TAPS)).
- SHIFT, 15: right-shift (fractional coefficient bits) applied to the accumulator before output.

Ports:
- ctx_clk, input, 1: tx clock.
- rtx_rst, input, 1: asynchronous active-low reset.
- etx_en, input, 1: module enable; low acts as a synchronous clear.
- isample, input, SAMPLE_BITS: signed sample to be filtered.
- inew_sample, input, 1: one-cycle strobe qualifying isample.
- ifilter_coefficient, input, COEF_BITS: signed coefficient from ROM, combinational response to oselect_coefficient.
- oselect_coefficient, output, 8: coefficient ROM address.
- osample, output, SAMPLE_BITS: signed filtered sample; held until the next update.
- osample_ready_trig, output, 1: one-cycle pulse when osample updates.
- obusy, output, 1: high whenever state is not IDLE.
- ooverrun, output, 1: sticky flag; a strobe arrived while busy.

Behaviour:
- Reset (rtx_rst low, asynchronous):
  - State goes to IDLE.
  - History buffer, write pointer, coefficient index, accumulator, osample, osample_ready_trig, ooverrun and oselect_coefficient all go to 0.
  - A reset during MAC aborts the computation; no trigger is produced.
- etx_en low: synchronously produces the same cleared state on the next edge. All inputs are ignored while low.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - If inew_sample is high, write isample to buf[wptr] and set newest <= wptr.
  - Advance wptr modulo TAPS, wrapping TAPS-1 -> 0.
  - Clear acc and k, then go to MAC.
- MAC, one tap per cycle for k = 0..TAPS-1:
  - oselect_coefficient = k.
  - acc <= acc + buf[(newest - k) mod TAPS] * ifilter_coefficient.
  - The buffer index wraps below 0 to TAPS-1.
  - The product is a full-precision signed multiply, sign-extended to ACC_BITS.
  - After k = TAPS-1, go to DONE.
- DONE:
  - Compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up); when SHIFT = 0 no rounding constant is added.
  - Saturate r to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1] and register it into osample.
  - Register osample_ready_trig <= 1, then go to IDLE.
- Latency:
  - If inew_sample is sampled at edge E, osample and osample_ready_trig are valid in the cycle after edge E+TAPS+1, i.e. TAPS+2 clocks after the strobe.
  - The trigger lasts exactly one cycle.
- Throughput:
  - Minimum strobe spacing is TAPS+2 clocks.
  - A strobe coinciding with the trigger cycle is accepted, since state is already IDLE.
- Overrun:
  - inew_sample in MAC or DONE is dropped; the buffer and computation are unaffected.
  - ooverrun is set and held until reset or etx_en low.
- oselect_coefficient in IDLE and DONE is 0 (pre-addresses the first tap).
- Empty history: after reset, unwritten entries are 0, so early outputs reflect zero-padded history.

Test Plan:
- Impulse response (TAPS=4, SHIFT=2, ROM [4,8,12,16]): samples 100,0,0,0,0 at spacing 6 -> osample 100,200,300,400,0. Each trigger is exactly 6 clocks after its strobe and one cycle wide.
- Wrap-around (TAPS=4, SHIFT=2, ROM [4,0,0,4]): ramp 1..10 -> outputs 1,2,3,5,7,...,17; the final output is 10+7=17.
- Rounding (TAPS=4, SHIFT=2, ROM [2,0,0,0]):
  - Sample 1 -> 1, since (2+2)>>>2.
  - Sample -1 -> 0.
  - Sample -3 -> -1, since (-6+2)>>>2.
- Saturation (defaults, all coefficients 32767):
  - 64 samples of 32767 -> osample 32767.
  - Then 64 samples of -32768 -> -32768.
  - No wrap to the opposite sign.
- Overrun: a second strobe 3 clocks after an accepted one -> ignored, ooverrun=1 and stays 1. The output equals the single-sample result; a subsequent etx_en low clears ooverrun.
- Reset mid-MAC: rtx_rst low at k=2 -> all outputs 0 immediately, with no trigger afterwards. After release, a fresh impulse reproduces the first scenario's values.
